// File: rtl/timer_prescaler_if.sv
// TCR-side view of the timer prescaler: the enable and clock-select fields go in,
// and the count-enable tick and debug state come out.
interface timer_prescaler_if #(
    parameter int DIV_W = 4
);
    logic             en;
    logic [1:0]       cks;
    logic             tick;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       cks_active;
    logic             busy;

    modport master (output en, cks, input tick, div_cnt, cks_active, busy);
    modport slave  (input en, cks, output tick, div_cnt, cks_active, busy);
endinterface

// File: rtl/timer_prescaler.sv
// Generates the TCNT count-enable: a single-cycle tick every 2/4/8/16 pclk cycles.
// Clock-select changes take effect only at a period boundary. Defining
// TIMER_PSC_EXT_CLK_EN adds a synchronized external clock source (ext_clk/ext_sel).
module timer_prescaler #(
    parameter int DIV_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                pclk,
    input  logic                preset_n,
    timer_prescaler_if.slave    bus
`ifdef TIMER_PSC_EXT_CLK_EN
    ,
    input  logic                ext_clk,
    input  logic                ext_sel
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, SWITCH} state_t;

    state_t           state_q, state_nxt;
    logic [DIV_W-1:0] div_q, div_nxt;
    logic [1:0]       act_q, act_nxt;
    logic [1:0]       pend_q, pend_nxt;
    logic             pflg_q, pflg_nxt;
    logic [DIV_W-1:0] last;
    logic             wrap;
    logic             tick;
    logic             ext_mode;
    logic             ext_pulse;

`ifdef TIMER_PSC_EXT_CLK_EN
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ext_prev_q;

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            sync_q     <= '0;
            ext_prev_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], ext_clk};
            ext_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign ext_pulse = sync_q[SYNC_STAGES-1] & ~ext_prev_q;
    assign ext_mode  = ext_sel;
`else
    assign ext_pulse = 1'b0;
    assign ext_mode  = 1'b0;
`endif

    always_comb begin
        last = DIV_W'(1);
        case (act_q)
            2'd0: last = DIV_W'(1);
            2'd1: last = DIV_W'(3);
            2'd2: last = DIV_W'(7);
            2'd3: last = DIV_W'(15);
            default: last = DIV_W'(1);
        endcase
    end

    assign wrap = (div_q == last);

    always_comb begin
        state_nxt = state_q;
        div_nxt   = div_q;
        act_nxt   = act_q;
        pend_nxt  = pend_q;
        pflg_nxt  = pflg_q;
        tick      = 1'b0;
        case (state_q)
            IDLE: begin
                div_nxt = '0;
                if (bus.en) begin
                    state_nxt = RUN;
                    act_nxt   = bus.cks;
                end
            end
            RUN, SWITCH: begin
                if (!bus.en) begin
                    // Dropping en abandons the partial period: no tick, no kept phase.
                    state_nxt = IDLE;
                    div_nxt   = '0;
                    pflg_nxt  = 1'b0;
                end else if (ext_mode) begin
                    tick    = ext_pulse;
                    div_nxt = '0;
                end else begin
                    tick    = wrap;
                    div_nxt = wrap ? '0 : div_q + DIV_W'(1);
                    if (state_q == RUN) begin
                        if (bus.cks != act_q) begin
                            state_nxt = SWITCH;
                            pend_nxt  = bus.cks;
                            pflg_nxt  = 1'b1;
                        end
                    end else if (wrap && pflg_q) begin
                        state_nxt = RUN;
                        act_nxt   = pend_q;
                        pflg_nxt  = 1'b0;
                    end else begin
                        pend_nxt = bus.cks;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                div_nxt   = '0;
                pflg_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            act_q   <= 2'd0;
            pend_q  <= 2'd0;
            pflg_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            div_q   <= div_nxt;
            act_q   <= act_nxt;
            pend_q  <= pend_nxt;
            pflg_q  <= pflg_nxt;
        end
    end

    assign bus.tick       = tick;
    assign bus.div_cnt    = div_q;
    assign bus.cks_active = act_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_timer_prescaler.sv
// Directed bench for timer_prescaler: reset, divide ratios, live switch,
// disable mid-period and coalesced clock-select changes.
module tb_timer_prescaler;
    logic pclk;
    logic preset_n;
    int   n_vec;
    int   n_err;
    int   cyc;
    int   tq[$];

    timer_prescaler_if #(.DIV_W(4)) bus();

`ifdef TIMER_PSC_EXT_CLK_EN
    logic ext_clk;
    logic ext_sel;
    timer_prescaler #(.DIV_W(4), .SYNC_STAGES(2)) dut (
        .pclk(pclk), .preset_n(preset_n), .bus(bus.slave),
        .ext_clk(ext_clk), .ext_sel(ext_sel)
    );
`else
    timer_prescaler #(.DIV_W(4), .SYNC_STAGES(2)) dut (
        .pclk(pclk), .preset_n(preset_n), .bus(bus.slave)
    );
`endif

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n cycles, sampling at the falling edge and logging tick cycles.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge pclk);
            cyc++;
            if (bus.tick) tq.push_back(cyc);
        end
    endtask

    task automatic restart(input logic [1:0] sel);
        bus.en = 1'b0;
        run(2);
        bus.cks = sel;
        bus.en  = 1'b1;
        cyc = 0;
        tq.delete();
    endtask

    task automatic chk_ticks(input string tag, input int exp[]);
        chk({tag, "_cnt"}, tq.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk(tag, (i < tq.size()) ? tq[i] : -1, exp[i]);
    endtask

    initial begin
        int m[4];
        int bad;
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        m = '{505, 1018, 2040, 4100};
        preset_n = 1'b0;
        bus.en   = 1'b1;
        bus.cks  = 2'b11;
`ifdef TIMER_PSC_EXT_CLK_EN
        ext_clk = 1'b0;
        ext_sel = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            chk("rst_tick", int'(bus.tick), 0);
            chk("rst_div", int'(bus.div_cnt), 0);
            chk("rst_busy", int'(bus.busy), 0);
            chk("rst_act", int'(bus.cks_active), 0);
        end
        bus.en = 1'b0;
        preset_n = 1'b1;

        // Divide ratios
        for (int k = 0; k < 4; k++) begin
            restart(2'(k));
            run(m[k]);
            chk("ratio_cnt", tq.size(), m[k] / (2 << k));
            chk("ratio_first", (tq.size() > 0) ? tq[0] : -1, 2 << k);
            bad = 0;
            for (int i = 1; i < tq.size(); i++)
                if (tq[i] - tq[i-1] != (2 << k)) bad++;
            chk("ratio_space", bad, 0);
        end

        // Live switch /2 -> /16
        restart(2'b00);
        run(5);
        bus.cks = 2'b11;
        run(1);
        chk("sw_old_act", int'(bus.cks_active), 0);
        chk("sw_wrap_tick", int'(bus.tick), 1);
        run(1);
        chk("sw_new_act", int'(bus.cks_active), 3);
        chk("sw_new_div", int'(bus.div_cnt), 0);
        run(33);
        chk_ticks("sw_ticks", '{2, 4, 6, 22, 38});

        // Disable mid-period
        restart(2'b10);
        run(7);
        @(negedge pclk);
        chk("dis_div7", int'(bus.div_cnt), 7);
        bus.en = 1'b0;
        #1;
        chk("dis_tick", int'(bus.tick), 0);
        chk("dis_noticks", tq.size(), 0);
        @(negedge pclk);
        chk("dis_busy", int'(bus.busy), 0);
        chk("dis_div", int'(bus.div_cnt), 0);
        bus.en = 1'b1;
        cyc = 0;
        tq.delete();
        run(10);
        chk_ticks("reen", '{8});

        // Multiple pending changes: last write wins at the /16 boundary
        restart(2'b11);
        run(3);
        bus.cks = 2'b01;
        run(2);
        bus.cks = 2'b10;
        run(11);
        chk("pend_old_act", int'(bus.cks_active), 3);
        chk("pend_wrap_tick", int'(bus.tick), 1);
        run(1);
        chk("pend_new_act", int'(bus.cks_active), 2);
        run(23);
        chk_ticks("pend_ticks", '{16, 24, 32, 40});

`ifdef TIMER_PSC_EXT_CLK_EN
        // External clock: one tick per ext_clk rising edge, divider parked at 0
        restart(2'b00);
        ext_sel = 1'b1;
        bad = 0;
        for (int e = 0; e < 20; e++) begin
            for (int j = 0; j < 10; j++) begin
                ext_clk = (j < 5) ? 1'b0 : 1'b1;
                run(1);
                if (bus.div_cnt != 0) bad++;
            end
        end
        run(10);
        chk("ext_ticks", tq.size(), 20);
        chk("ext_div", bad, 0);
        ext_sel = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
